// File: rtl/cv_ctrl_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cv_ctrl_scanner                                                 |
// | Brief    : Two-port controller scanner: joystick/keypad select, debounce.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cv_ctrl_scanner #(
  parameter int SETTLE   = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_i,
  input  logic       scan_en_i,
  output logic [1:0] ctrl_p5_o,
  output logic [1:0] ctrl_p8_o,
  input  logic [1:0] ctrl_p1_i,
  input  logic [1:0] ctrl_p2_i,
  input  logic [1:0] ctrl_p3_i,
  input  logic [1:0] ctrl_p4_i,
  input  logic [1:0] ctrl_p6_i,
  output logic [3:0] key0_o,
  output logic [3:0] key1_o,
  output logic [5:0] joy0_o,
  output logic [5:0] joy1_o,
  output logic       valid_o,
  output logic       changed_o
);

  localparam int c_SET_W = $clog2(SETTLE + 1);
  localparam int c_DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE - 1);
  localparam logic [c_DB_W-1:0]  c_DB_MAX   = c_DB_W'(DEBOUNCE - 1);
  localparam logic [19:0]        c_RELEASED = {4'hF, 4'hF, 6'h00, 6'h00};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP_J = 3'd1,
    S_SEL_J = 3'd2,
    S_SMP_J = 3'd3,
    S_GAP_K = 3'd4,
    S_SEL_K = 3'd5,
    S_SMP_K = 3'd6,
    S_PUB   = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_SET_W-1:0]   r_settle;
  logic [c_SET_W-1:0]   w_settle_nxt;
  logic [c_DB_W-1:0]    r_db;
  logic [c_DB_W-1:0]    w_db_nxt;
  logic                 w_load;
  logic                 w_sel_j_nxt;
  logic                 w_sel_k_nxt;
  logic [3:0]           r_raw_key0;
  logic [3:0]           r_raw_key1;
  logic [5:0]           r_raw_joy0;
  logic [5:0]           r_raw_joy1;
  logic [19:0]          r_prev;
  logic [19:0]          w_raw_vec;
  logic [19:0]          w_out_vec;
  logic [3:0]           r_key0;
  logic [3:0]           r_key1;
  logic [5:0]           r_joy0;
  logic [5:0]           r_joy1;
  logic [1:0]           r_p5;
  logic [1:0]           r_p8;
  logic                 r_valid;
  logic                 r_changed;

  // Nibble is {p1,p2,p3,p4} as seen on the wire (active-low encoding).
  function automatic logic [3:0] f_key_decode(input logic [3:0] nib);
    logic [3:0] key;
    case (nib)
      4'b0011: key = 4'd0;
      4'b1110: key = 4'd1;
      4'b1101: key = 4'd2;
      4'b0110: key = 4'd3;
      4'b0001: key = 4'd4;
      4'b1001: key = 4'd5;
      4'b0111: key = 4'd6;
      4'b1100: key = 4'd7;
      4'b1000: key = 4'd8;
      4'b1011: key = 4'd9;
      4'b1010: key = 4'd10;
      4'b0101: key = 4'd11;
      4'b0100: key = 4'd12;
      4'b0010: key = 4'd13;
      default: key = 4'd15;
    endcase
    return key;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    case (r_state)
      S_IDLE:  if (scan_en_i) w_state_nxt = S_GAP_J;
      S_GAP_J: begin
        w_state_nxt  = S_SEL_J;
        w_settle_nxt = '0;
      end
      S_SEL_J: begin
        if (r_settle == c_SET_LAST) begin
          w_state_nxt  = S_SMP_J;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      S_SMP_J: w_state_nxt = S_GAP_K;
      S_GAP_K: begin
        w_state_nxt  = S_SEL_K;
        w_settle_nxt = '0;
      end
      S_SEL_K: begin
        if (r_settle == c_SET_LAST) begin
          w_state_nxt  = S_SMP_K;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      S_SMP_K: w_state_nxt = S_PUB;
      S_PUB:   w_state_nxt = scan_en_i ? S_GAP_J : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_j_nxt = (w_state_nxt == S_SEL_J) || (w_state_nxt == S_SMP_J);
    w_sel_k_nxt = (w_state_nxt == S_SEL_K) || (w_state_nxt == S_SMP_K);
    w_raw_vec   = {r_raw_key1, r_raw_key0, r_raw_joy1, r_raw_joy0};
    w_out_vec   = {r_key1, r_key0, r_joy1, r_joy0};
    if (w_raw_vec != r_prev) begin
      w_db_nxt = '0;
    end else if (r_db == c_DB_MAX) begin
      w_db_nxt = c_DB_MAX;
    end else begin
      w_db_nxt = r_db + 1'b1;
    end
    w_load = (w_db_nxt == c_DB_MAX);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_settle   <= '0;
      r_db       <= '0;
      r_raw_key0 <= 4'hF;
      r_raw_key1 <= 4'hF;
      r_raw_joy0 <= '0;
      r_raw_joy1 <= '0;
      r_prev     <= c_RELEASED;
      r_key0     <= 4'hF;
      r_key1     <= 4'hF;
      r_joy0     <= '0;
      r_joy1     <= '0;
      r_p5       <= 2'b11;
      r_p8       <= 2'b11;
      r_valid    <= 1'b0;
      r_changed  <= 1'b0;
    end else begin
      // Pulses are one clk_i wide regardless of the tick enable.
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      if (clk_en_i) begin
        r_state  <= w_state_nxt;
        r_settle <= w_settle_nxt;
        r_p8     <= w_sel_j_nxt ? 2'b00 : 2'b11;
        r_p5     <= w_sel_k_nxt ? 2'b00 : 2'b11;
        case (r_state)
          S_SMP_J: begin
            r_raw_joy0[4:0] <= ~{ctrl_p6_i[0], ctrl_p4_i[0], ctrl_p3_i[0],
                                 ctrl_p2_i[0], ctrl_p1_i[0]};
            r_raw_joy1[4:0] <= ~{ctrl_p6_i[1], ctrl_p4_i[1], ctrl_p3_i[1],
                                 ctrl_p2_i[1], ctrl_p1_i[1]};
          end
          S_SMP_K: begin
            r_raw_key0    <= f_key_decode({ctrl_p1_i[0], ctrl_p2_i[0],
                                           ctrl_p3_i[0], ctrl_p4_i[0]});
            r_raw_key1    <= f_key_decode({ctrl_p1_i[1], ctrl_p2_i[1],
                                           ctrl_p3_i[1], ctrl_p4_i[1]});
            r_raw_joy0[5] <= ~ctrl_p6_i[0];
            r_raw_joy1[5] <= ~ctrl_p6_i[1];
          end
          S_PUB: begin
            r_prev  <= w_raw_vec;
            r_db    <= w_db_nxt;
            r_valid <= 1'b1;
            if (w_load) begin
              {r_key1, r_key0, r_joy1, r_joy0} <= w_raw_vec;
              r_changed <= (w_raw_vec != w_out_vec);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ctrl_p5_o = r_p5;
  assign ctrl_p8_o = r_p8;
  assign key0_o    = r_key0;
  assign key1_o    = r_key1;
  assign joy0_o    = r_joy0;
  assign joy1_o    = r_joy1;
  assign valid_o   = r_valid;
  assign changed_o = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_cv_ctrl_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cv_ctrl_scanner                                              |
// | Brief    : Scoreboard bench for cv_ctrl_scanner with a controller model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cv_ctrl_scanner;

  localparam int SETTLE   = 8;
  localparam int DEBOUNCE = 2;
  localparam logic [19:0] c_REL = {4'hF, 4'hF, 6'h00, 6'h00};

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       scan_en;
  logic [1:0] p1, p2, p3, p4, p5, p6, p8;
  logic [3:0] key0, key1;
  logic [5:0] joy0, joy1;
  logic       valid, changed;

  cv_ctrl_scanner #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) u_dut (
    .clk_i     (clk_sys),
    .reset_n_i (rst_n),
    .clk_en_i  (clk_en),
    .scan_en_i (scan_en),
    .ctrl_p5_o (p5),
    .ctrl_p8_o (p8),
    .ctrl_p1_i (p1),
    .ctrl_p2_i (p2),
    .ctrl_p3_i (p3),
    .ctrl_p4_i (p4),
    .ctrl_p6_i (p6),
    .key0_o    (key0),
    .key1_o    (key1),
    .joy0_o    (joy0),
    .joy1_o    (joy1),
    .valid_o   (valid),
    .changed_o (changed)
  );

  always #5 clk_sys = ~clk_sys;

  // Controller state per port: joystick {fire,right,left,down,up}, keypad wire nibble, arm.
  logic [4:0] ctl_joy [2];
  logic [3:0] ctl_nib [2];
  logic       ctl_arm [2];

  always_comb begin
    p1 = 2'b11; p2 = 2'b11; p3 = 2'b11; p4 = 2'b11; p6 = 2'b11;
    for (int n = 0; n < 2; n++) begin
      if (!p8[n]) begin
        p1[n] = ~ctl_joy[n][0];
        p2[n] = ~ctl_joy[n][1];
        p3[n] = ~ctl_joy[n][2];
        p4[n] = ~ctl_joy[n][3];
        p6[n] = ~ctl_joy[n][4];
      end else if (!p5[n]) begin
        {p1[n], p2[n], p3[n], p4[n]} = ctl_nib[n];
        p6[n] = ~ctl_arm[n];
      end
    end
  end

  // Wire nibble -> key code, indexed by {p1,p2,p3,p4}.
  int dec_tab [16] = '{15, 4, 13, 0, 12, 11, 3, 6, 8, 5, 10, 9, 7, 2, 1, 15};

  typedef struct packed {
    logic [19:0] outv;
    logic        chg;
  } exp_t;

  exp_t        sb_q [$];
  logic [19:0] hist [$];
  logic [19:0] m_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_period;
  int en_mode;
  int en_cnt;
  int cyc, last_cyc, last_per;
  logic prev_v;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [19:0] raw_now();
    return {4'(dec_tab[ctl_nib[1]]), 4'(dec_tab[ctl_nib[0]]),
            ctl_arm[1], ctl_joy[1], ctl_arm[0], ctl_joy[0]};
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(c_REL);
    m_out = c_REL;
  endtask

  // Outputs take a scan's value once the last DEBOUNCE scans (history seeded
  // with the released vector) are all identical.
  task automatic push_scan();
    logic [19:0] raw, nv;
    bit same;
    exp_t e;
    raw = raw_now();
    hist.push_back(raw);
    if (hist.size() > DEBOUNCE) void'(hist.pop_front());
    same = (hist.size() == DEBOUNCE);
    foreach (hist[i]) if (hist[i] != raw) same = 0;
    nv = same ? raw : m_out;
    e.outv = nv;
    e.chg  = (nv != m_out);
    sb_q.push_back(e);
    m_out = nv;
  endtask

  task automatic set_ctrl(input logic [4:0] j0, input logic [4:0] j1,
                          input logic [3:0] n0, input logic [3:0] n1,
                          input logic a0, input logic a1);
    ctl_joy[0] = j0; ctl_joy[1] = j1;
    ctl_nib[0] = n0; ctl_nib[1] = n1;
    ctl_arm[0] = a0; ctl_arm[1] = a1;
  endtask

  task automatic rand_ctrl();
    set_ctrl(5'($urandom), 5'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom));
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk_sys);
      if (valid) break;
    end
    if (k == 1000) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout_valid %s: got no valid_o expected one within 1000 cycles", tag);
    end
  endtask

  task automatic wait_sel_k(input string tag);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk_sys);
      if (p5 == 2'b00) break;
    end
    if (k == 1000) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout_selk %s: got p5=%b expected 00 within 1000 cycles", tag, p5);
    end
  endtask

  // Tick-enable generator.
  initial begin
    clk_en = 1'b1;
    en_cnt = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      case (en_mode)
        0:       clk_en = 1'b1;
        1: begin
          clk_en = (en_cnt % 3 == 0);
          en_cnt++;
        end
        default: clk_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: select overlap, pulse width, scan period and scoreboard pops.
  initial begin
    exp_t e;
    cyc = 0; last_cyc = 0; last_per = 0; prev_v = 1'b0;
    forever begin
      @(negedge clk_sys);
      cyc++;
      check("sel_overlap", {30'b0, ~p5 & ~p8}, 32'd0);
      if (valid) begin
        check("valid_width", {31'b0, prev_v}, 32'd0);
        if (sb_q.size() == 0) begin
          check("valid_unexpected", {31'b0, valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("scan_out", {12'b0, key1, key0, joy1, joy0}, {12'b0, e.outv});
          check("changed", {31'b0, changed}, {31'b0, e.chg});
        end
        if (exp_period != 0 && last_per == exp_period)
          check("period", cyc - last_cyc, exp_period);
        last_cyc = cyc;
        last_per = exp_period;
      end else if (changed) begin
        check("changed_no_valid", {31'b0, changed}, 32'd0);
      end
      prev_v = valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    rst_n = 1'b0; scan_en = 1'b0; en_mode = 0; exp_period = 0;
    set_ctrl(5'd0, 5'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk_sys);
    check("rst_sel", {28'b0, p5, p8}, 32'hF);
    check("rst_keys", {24'b0, key1, key0}, 32'hFF);
    check("rst_joys", {20'b0, joy1, joy0}, 32'd0);
    check("rst_pulses", {30'b0, valid, changed}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // Joystick: port0 up + fire.
    exp_period = 21;
    set_ctrl(5'b10001, 5'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    push_scan();
    scan_en = 1'b1;
    wait_valid("joy_1");
    check("joy0_after1", {26'b0, joy0}, 32'd0);
    push_scan();
    wait_valid("joy_2");
    check("joy0_after2", {26'b0, joy0}, 32'h11);
    push_scan();
    wait_valid("joy_3");

    // Keypad on port1: 0, then '*'.
    set_ctrl(5'd0, 5'd0, 4'hF, 4'b0011, 1'b0, 1'b0);
    repeat (2) begin push_scan(); wait_valid("key_0"); end
    check("key1_zero", {28'b0, key1}, 32'd0);
    ctl_nib[1] = 4'b1010;
    repeat (2) begin push_scan(); wait_valid("key_star"); end
    check("key1_star", {28'b0, key1}, 32'd10);
    check("key0_none", {28'b0, key0}, 32'd15);

    // Single-scan glitch between released scans.
    ctl_nib[1] = 4'hF;
    repeat (3) begin push_scan(); wait_valid("glitch_pre"); end
    ctl_nib[1] = 4'b1000;
    push_scan(); wait_valid("glitch");
    ctl_nib[1] = 4'hF;
    repeat (2) begin push_scan(); wait_valid("glitch_post"); end
    check("key1_glitch", {28'b0, key1}, 32'd15);

    // Tick enable every third clock.
    exp_period = 0;
    en_mode = 1;
    hold = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) exp_period = 63;
      if (hold == 0) begin rand_ctrl(); hold = $urandom_range(1, 3); end
      hold--;
      push_scan();
      wait_valid("en3");
    end

    // Random data, random enable.
    exp_period = 0;
    en_mode = 2;
    hold = 0;
    for (int i = 0; i < 30; i++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 4) == 0) set_ctrl(5'd0, 5'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        else rand_ctrl();
        hold = $urandom_range(1, 3);
      end
      hold--;
      push_scan();
      wait_valid("rand");
    end

    // Stop during SEL_K: the scan completes, then the block idles.
    en_mode = 0;
    rand_ctrl();
    push_scan();
    wait_sel_k("stop");
    scan_en = 1'b0;
    wait_valid("stop");
    repeat (60) @(negedge clk_sys);
    check("idle_sel", {28'b0, p5, p8}, 32'hF);

    // Reset asserted mid-SEL_K abandons the scan.
    rand_ctrl();
    push_scan();
    scan_en = 1'b1;
    wait_sel_k("reset");
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", {28'b0, p5, p8}, 32'hF);
    check("mid_rst_keys", {24'b0, key1, key0}, 32'hFF);
    check("mid_rst_joys", {20'b0, joy1, joy0}, 32'd0);
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    sb_q.delete();
    model_reset();
    repeat (4) @(negedge clk_sys);
    check("rst_hold_valid", {31'b0, valid}, 32'd0);
    set_ctrl(5'b00100, 5'b01000, 4'b1110, 4'b0101, 1'b1, 1'b0);
    push_scan();
    rst_n = 1'b1;
    wait_valid("after_rst_1");
    push_scan();
    wait_valid("after_rst_2");
    check("after_rst_key0", {28'b0, key0}, 32'd1);
    push_scan();
    scan_en = 1'b0;
    wait_valid("final");
    repeat (30) @(negedge clk_sys);
    check("sb_drain", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv_ctrl_scanner.md
CV_CTRL_SCANNER -- requirements
Module: cv_ctrl_scanner

Interface
REQ-001 Parameter SETTLE, default 8: enable ticks a select is held active before sampling.
REQ-002 Parameter DEBOUNCE, default 2: consecutive identical scans required before outputs update.
REQ-003 clk_i  in  1  system clock; the block's only clock.
REQ-004 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-005 clk_en_i  in  1  tick enable; all state advances only on clk_i edges with clk_en_i=1.
REQ-006 scan_en_i  in  1  1 = scan continuously, 0 = finish the current scan, then idle.
REQ-007 ctrl_p5_o  out  2  keypad select per port [port], active-low.
REQ-008 ctrl_p8_o  out  2  joystick select per port [port], active-low.
REQ-009 ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i  in  2 each  controller data lines per port, active-low.
REQ-010 ctrl_p6_i  in  2  fire/arm line per port, active-low.
REQ-011 key0_o, key1_o  out  4 each  decoded keypad: 0-9 digit, 10 = *, 11 = #, 12 = purple trigger, 13 = blue trigger, 15 = none.
REQ-012 joy0_o, joy1_o  out  6 each  {arm, fire, right, left, down, up}, active-high.
REQ-013 valid_o  out  1  one-clk_i pulse per completed scan.
REQ-014 changed_o  out  1  one-clk_i pulse, coincident with valid_o, when any key/joy output changed.

Function
REQ-015 States, each lasting the stated number of enable ticks: IDLE; GAP_J (1); SEL_J (SETTLE); SMP_J (1); GAP_K (1); SEL_K (SETTLE); SMP_K (1); PUB (1); scan period = 2*SETTLE+5 ticks.
REQ-016 Select outputs:
  - GAP_J, GAP_K, PUB and IDLE: ctrl_p5_o=11, ctrl_p8_o=11.
  - SEL_J and SMP_J: ctrl_p8_o=00, ctrl_p5_o=11.
  - SEL_K and SMP_K: ctrl_p5_o=00, ctrl_p8_o=11.
  - Both selects are never low together (break-before-make).
REQ-017 IDLE -> GAP_J when scan_en_i=1; PUB -> GAP_J if scan_en_i=1, else IDLE; scan_en_i is sampled only in IDLE and PUB.
REQ-018 SMP_J tick, per port: raw up=~p1, down=~p2, left=~p3, right=~p4, fire=~p6.
REQ-019 SMP_K tick, per port: nibble {p1,p2,p3,p4} decodes as
  - 0011=0, 1110=1, 1101=2, 0110=3, 0001=4, 1001=5, 0111=6, 1100=7, 1000=8, 1011=9;
  - 1010=10, 0101=11, 0100=12, 0010=13;
  - 1111 and 0000 = 15.
  - Raw arm = ~p6.
REQ-020 PUB tick debounce: the 20-bit raw vector (both ports) is compared with the previous scan's raw vector.
  - Equal: stable count increments, saturating at DEBOUNCE-1. Not equal: count resets to 0.
  - The previous raw vector is updated every PUB tick.
REQ-021 When the stable count equals DEBOUNCE-1 at PUB, key/joy outputs load the raw values; otherwise they hold. DEBOUNCE=1 means the outputs load every scan.
REQ-022 valid_o is high for exactly the one clk_i cycle following the PUB tick edge. changed_o is high in that same cycle only if the loaded values differ from the prior outputs.
REQ-023 clk_en_i=0 freezes all state and counters; valid_o/changed_o still last one clk_i cycle.
REQ-024 Settle counter width is $clog2(SETTLE+1); SETTLE>=1 is required.

Reset
REQ-025 While reset_n_i=0, asynchronously:
  - state=IDLE;
  - ctrl_p5_o=11, ctrl_p8_o=11;
  - key0_o=key1_o=15, joy0_o=joy1_o=0;
  - valid_o=changed_o=0;
  - counters 0; previous raw vector = all-released (keys 15, joy 0).
REQ-026 Reset asserted mid-scan abandons the scan with no valid_o pulse. Scanning restarts at GAP_J on the first enabled tick after release if scan_en_i=1.

Verification
REQ-027 Reset: assert reset_n_i mid-SEL_K -> selects read 11, keys 15, joys 0 in the same cycle, no valid_o.
REQ-028 Joystick, clk_en_i=1, SETTLE=8: port0 model pulls p1 and p6 low while p8[0]=0.
  - valid_o pulses at 21-clock intervals.
  - joy0_o=6'b010001 after the 2nd valid_o, not after the 1st; changed_o only with the 2nd.
REQ-029 Keypad: port1 returns 0011 while p5[1]=0 -> key1_o=0 after 2 scans; then returning 1010 -> key1_o=10 two scans later; key0_o stays 15.
REQ-030 Glitch: nibble 1000 for a single scan between steady 1111 scans -> key outputs stay 15, changed_o never pulses.
REQ-031 Stop and select overlap: drop scan_en_i during SEL_K -> scan completes, one valid_o, then selects stay 11. A monitor confirms p5 and p8 are never both 0 on any port throughout.
REQ-032 Enable gating: clk_en_i every 3rd cycle -> scan period 63 clocks; valid_o remains one clock wide.
